// File: rtl/meta_pkg.sv
// Shared constants for the SUMP metadata streamer: tags, field offsets,
// byte-list length, FSM state encoding and byte-extraction helpers.
package meta_pkg;

  localparam int META_LEN = 47;

  localparam logic [7:0] TAG_NAME   = 8'h01;
  localparam logic [7:0] TAG_FW     = 8'h02;
  localparam logic [7:0] TAG_MEM    = 8'h21;
  localparam logic [7:0] TAG_RATE   = 8'h23;
  localparam logic [7:0] TAG_PROBES = 8'h40;
  localparam logic [7:0] TAG_PROTO  = 8'h41;
  localparam logic [7:0] TAG_END    = 8'h00;

  localparam int OFS_NAME   = 0;
  localparam int OFS_FW     = 26;
  localparam int OFS_MEM    = 32;
  localparam int OFS_RATE   = 37;
  localparam int OFS_PROBES = 42;
  localparam int OFS_PROTO  = 44;
  localparam int OFS_END    = 46;

  localparam int NAME_LEN = 24;
  localparam int FW_LEN   = 4;

  localparam logic [191:0] NAME_STR = "Open Logic Sniffer v1.01";
  localparam logic [191:0] FW_STR   = {160'h0, "3.01"};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_POLL  = 2'd3;

  // Character i (0 = leftmost) of a right-aligned string of len chars.
  function automatic logic [7:0] str_byte(
    input logic [191:0] s,
    input int           len,
    input int           i
  );
    logic [191:0] t;
    t = s >> (8 * (len - 1 - i));
    return t[7:0];
  endfunction

  // Byte k of a 32-bit field, k = 0 being the MSB.
  function automatic logic [7:0] field_byte(
    input logic [31:0] v,
    input int          k
  );
    logic [31:0] t;
    t = v >> (8 * (3 - k));
    return t[7:0];
  endfunction

endpackage

// File: rtl/meta_rom.sv
// Index -> byte lookup for the metadata list, with capability fields
// patched in from the i_mem_bytes / i_max_rate / i_probes inputs.
// Ports: i_idx byte index; i_mem_bytes, i_max_rate, i_probes field values;
//        o_byte selected byte (unused entries and terminator read 0).
module meta_rom
  import meta_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter logic [7:0] PROTO_VER = 8'h02
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_mem_bytes,
  input  logic [31:0]       i_max_rate,
  input  logic [7:0]        i_probes,
  output logic [7:0]        o_byte
);

  int w_a;
  assign w_a = int'(i_idx);

  always_comb begin
    o_byte = TAG_END;
    unique case (1'b1)
      (w_a == OFS_NAME):
        o_byte = TAG_NAME;
      (w_a > OFS_NAME && w_a <= OFS_NAME + NAME_LEN):
        o_byte = str_byte(NAME_STR, NAME_LEN, w_a - OFS_NAME - 1);
      (w_a == OFS_FW):
        o_byte = TAG_FW;
      (w_a > OFS_FW && w_a <= OFS_FW + FW_LEN):
        o_byte = str_byte(FW_STR, FW_LEN, w_a - OFS_FW - 1);
      (w_a == OFS_MEM):
        o_byte = TAG_MEM;
      (w_a > OFS_MEM && w_a <= OFS_MEM + 4):
        o_byte = field_byte(i_mem_bytes, w_a - OFS_MEM - 1);
      (w_a == OFS_RATE):
        o_byte = TAG_RATE;
      (w_a > OFS_RATE && w_a <= OFS_RATE + 4):
        o_byte = field_byte(i_max_rate, w_a - OFS_RATE - 1);
      (w_a == OFS_PROBES):
        o_byte = TAG_PROBES;
      (w_a == OFS_PROBES + 1):
        o_byte = i_probes;
      (w_a == OFS_PROTO):
        o_byte = TAG_PROTO;
      (w_a == OFS_PROTO + 1):
        o_byte = PROTO_VER;
      default:
        o_byte = TAG_END;
    endcase
  end

endmodule

// File: rtl/meta_streamer.sv
// SUMP metadata streamer: feeds the tagged metadata byte list into the
// spi_transmitter one byte per idle slot, with abort and busy/done status.
// Ports: clock, extReset (async, active-high); query_metadata, abort,
//        xmit_idle; cfg_mem_bytes/cfg_max_rate/cfg_probes (runtime fields);
//        write_meta/meta_data byte strobe; busy; done pulse.
// Build option: META_DYNAMIC_EN patches capability fields from cfg_* inputs
// latched at accept; otherwise the DEF_* parameters are reported.
module meta_streamer
  import meta_pkg::*;
#(
  parameter int          ADDR_W        = 6,
  parameter logic [31:0] DEF_MEM_BYTES = 32'h0000_6000,
  parameter logic [31:0] DEF_MAX_RATE  = 32'h0BEB_C200,
  parameter logic [7:0]  DEF_PROBES    = 8'd32,
  parameter logic [7:0]  PROTO_VER     = 8'h02
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        query_metadata,
  input  logic        abort,
  input  logic        xmit_idle,
  input  logic [31:0] cfg_mem_bytes,
  input  logic [31:0] cfg_max_rate,
  input  logic [7:0]  cfg_probes,
  output logic        write_meta,
  output logic [7:0]  meta_data,
  output logic        busy,
  output logic        done
);

  if (META_LEN >= 2 ** ADDR_W) begin : g_len_chk
    $error("meta_streamer: ADDR_W too narrow for META_LEN");
  end

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_armed;
  logic              r_write;
  logic [7:0]        r_data;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_rom;
  logic [31:0]       w_mem;
  logic [31:0]       w_rate;
  logic [7:0]        w_probes;

  assign w_accept = (r_state == ST_IDLE) && query_metadata
                 && r_armed && xmit_idle && !abort;
  assign w_last   = (r_idx == ADDR_W'(META_LEN));
  // The accept edge loads byte 0 while r_idx may still hold a stale value.
  assign w_addr   = (r_state == ST_IDLE) ? '0 : r_idx;

`ifdef META_DYNAMIC_EN
  logic [31:0] r_mem_bytes;
  logic [31:0] r_max_rate;
  logic [7:0]  r_probes;

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      r_mem_bytes <= DEF_MEM_BYTES;
      r_max_rate  <= DEF_MAX_RATE;
      r_probes    <= DEF_PROBES;
    end else if (w_accept) begin
      r_mem_bytes <= cfg_mem_bytes;
      r_max_rate  <= cfg_max_rate;
      r_probes    <= cfg_probes;
    end
  end

  assign w_mem    = r_mem_bytes;
  assign w_rate   = r_max_rate;
  assign w_probes = r_probes;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cfg_mem_bytes, cfg_max_rate, cfg_probes};

  assign w_mem    = DEF_MEM_BYTES;
  assign w_rate   = DEF_MAX_RATE;
  assign w_probes = DEF_PROBES;
`endif

  meta_rom #(
    .ADDR_W    (ADDR_W),
    .PROTO_VER (PROTO_VER)
  ) u_rom (
    .i_idx       (w_addr),
    .i_mem_bytes (w_mem),
    .i_max_rate  (w_rate),
    .i_probes    (w_probes),
    .o_byte      (w_rom)
  );

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_armed <= 1'b1;
      r_write <= 1'b0;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      if (!query_metadata) r_armed <= 1'b1;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_state <= ST_SEND;
              r_idx   <= '0;
              r_armed <= 1'b0;
              r_busy  <= 1'b1;
              r_write <= 1'b1;
              r_data  <= w_rom;
            end
          end
          ST_SEND: begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_GUARD;
          end
          // Transmitter is still reporting idle for the byte just sent.
          ST_GUARD: r_state <= ST_POLL;
          ST_POLL: begin
            if (xmit_idle) begin
              if (w_last) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_SEND;
                r_write <= 1'b1;
                r_data  <= w_rom;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign write_meta = r_write & ~abort;
  assign meta_data  = r_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
